// File: rtl/digital_trainer_kit.sv
// Two-input logic-gate trainer: seven combinational gate outputs plus a clocked lab
// monitor (registered gates, truth-table coverage, saturating input-change counter).
module digital_trainer_kit #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             and_out,
    output logic             or_out,
    output logic             not_a,
    output logic             nand_out,
    output logic             nor_out,
    output logic             xor_out,
    output logic             xnor_out,
    output logic [6:0]       gates_q,
    output logic [3:0]       seen_mask,
    output logic             all_seen,
    output logic [CNT_W-1:0] edge_count
);

    function automatic logic [6:0] gate_vec(input logic x, input logic y);
        return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
    endfunction

    assign and_out  = a & b;
    assign or_out   = a | b;
    assign not_a    = ~a;
    assign nand_out = ~(a & b);
    assign nor_out  = ~(a | b);
    assign xor_out  = a ^ b;
    assign xnor_out = ~(a ^ b);

    // ab_s packs the synchronized operands as {a_s, b_s}
    logic [1:0] ab_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ab_s = {a, b};
        end else begin : g_sync
            logic [1:0] sync_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
                end else begin
                    sync_q[0] <= {a, b};
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign ab_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [6:0]       gates_reg_q;
    logic [3:0]       seen_q, seen_d;
    logic             all_seen_q;
    logic [1:0]       prev_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        seen_d  = seen_q | (4'b0001 << ab_s);
        count_d = count_q;
        // a two-bit compare makes a simultaneous a/b change a single increment
        if ((ab_s != prev_q) && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gates_reg_q <= 7'b0;
            seen_q      <= 4'b0;
            all_seen_q  <= 1'b0;
            prev_q      <= 2'b00;
            count_q     <= '0;
        end else begin
            gates_reg_q <= gate_vec(ab_s[1], ab_s[0]);
            seen_q      <= seen_d;
            all_seen_q  <= &seen_d;
            prev_q      <= ab_s;
            count_q     <= count_d;
        end
    end

    assign gates_q    = gates_reg_q;
    assign seen_mask  = seen_q;
    assign all_seen   = all_seen_q;
    assign edge_count = count_q;

endmodule

// File: tb/tb_digital_trainer_kit.sv
// Bench for digital_trainer_kit: directed checks plus a random run scored against a
// truth-table based reference model through an expected-value queue.
module tb_digital_trainer_kit;

    localparam int SYNC    = 2;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic and_out, or_out, not_a, nand_out, nor_out, xor_out, xnor_out;
    logic [6:0] gates_q;
    logic [3:0] seen_mask;
    logic all_seen;
    logic [CW-1:0] edge_count;

    digital_trainer_kit #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .and_out(and_out), .or_out(or_out), .not_a(not_a), .nand_out(nand_out),
        .nor_out(nor_out), .xor_out(xor_out), .xnor_out(xnor_out),
        .gates_q(gates_q), .seen_mask(seen_mask), .all_seen(all_seen),
        .edge_count(edge_count)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    endtask

    // Truth tables indexed by {a,b}: bit k is the output for ab == k
    function automatic logic [6:0] gates_of(input logic [1:0] ab);
        logic [3:0] t_and, t_or, t_not, t_nand, t_nor, t_xor, t_xnor;
        t_and  = 4'b1000; t_or  = 4'b1110; t_not  = 4'b0011; t_nand = 4'b0111;
        t_nor  = 4'b0001; t_xor = 4'b0110; t_xnor = 4'b1001;
        return {t_xnor[ab], t_xor[ab], t_nor[ab], t_nand[ab], t_not[ab], t_or[ab], t_and[ab]};
    endfunction

    function automatic logic [6:0] comb_now();
        return {xnor_out, xor_out, nor_out, nand_out, not_a, or_out, and_out};
    endfunction

    typedef struct {
        logic [6:0] g;
        logic [3:0] m;
        logic       all;
        int         cnt;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] pipe[$];
    logic [1:0] m_prev;
    logic [3:0] m_mask;
    int         m_cnt;

    function automatic void model_reset();
        pipe = {};
        for (int i = 0; i < SYNC; i++) pipe.push_back(2'b00);
        m_prev = 2'b00;
        m_mask = 4'b0;
        m_cnt  = 0;
    endfunction

    // Reference model: pins delayed SYNC samples, then coverage/count rules applied
    always @(posedge clk or posedge rst) begin
        exp_t e;
        logic [1:0] cur;
        if (rst) begin
            model_reset();
        end else begin
            pipe.push_back({a, b});
            cur = pipe.pop_front();
            if (cur != m_prev) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_prev = cur;
            m_mask = m_mask | (4'b0001 << cur);
            e.g   = gates_of(cur);
            e.m   = m_mask;
            e.all = (m_mask == 4'hF);
            e.cnt = m_cnt;
            sb.push_back(e);
        end
    end

    // Monitor: the DUT presents a new monitor state every cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_gates_q", gates_q, e.g);
            chk("sb_seen_mask", seen_mask, e.m);
            chk("sb_all_seen", all_seen, e.all);
            chk("sb_edge_count", edge_count, e.cnt);
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        clk_en = 1'b0;
        a = 1'b0;
        b = 1'b0;
        #2 rst = 1'b1;
        #3 clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_gates_q"}, gates_q, 0);
        chk({tag, "_seen_mask"}, seen_mask, 0);
        chk({tag, "_all_seen"}, all_seen, 0);
        chk({tag, "_edge_count"}, edge_count, 0);
    endtask

    initial begin
        logic [1:0] ab;
        logic [3:0] cov_exp;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_cleared("reset");

        // combinational sweep, clock idle, reset held
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            {a, b} = ab;
            #10;
            chk($sformatf("comb_ab%0d", i), comb_now(), gates_of(ab));
            $display("comb ab=%b outputs=%b", ab, comb_now());
        end
        chk("comb_no_clock_gates_q", gates_q, 0);

        a = 1'b0;
        b = 1'b0;
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // latency: 00 -> 11 appears after exactly SYNC+1 rising edges
        repeat (3) @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_edge%0d", k), gates_q,
                (k <= SYNC) ? gates_of(2'b00) : gates_of(2'b11));
            $display("latency edge=%0d gates_q=%b", k, gates_q);
        end

        // coverage walk
        pulse_reset();
        cov_exp = 4'b0;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            {a, b} = ab;
            cov_exp = cov_exp | (4'b0001 << ab);
            repeat (4) @(negedge clk);
            chk($sformatf("cov_mask_ab%0d", i), seen_mask, cov_exp);
            chk($sformatf("cov_all_ab%0d", i), all_seen, (i == 3));
            $display("coverage ab=%b seen_mask=%b all_seen=%b", ab, seen_mask, all_seen);
        end

        // counter: initial 00 uncounted, 00->11 is one step, then saturation
        pulse_reset();
        repeat (5) @(negedge clk);
        chk("cnt_first_00", edge_count, 0);
        a = 1'b1;
        b = 1'b1;
        repeat (5) @(negedge clk);
        chk("cnt_simultaneous", edge_count, 1);
        for (int i = 0; i < 300; i++) begin
            a = ~a;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("cnt_saturate", edge_count, CNT_MAX);
        $display("counter after 300 toggles edge_count=%0d", edge_count);

        // random run scored purely by the monitor
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) {a, b} = 2'($urandom_range(0, 3));
            @(negedge clk);
        end

        // asynchronous reset with the clock stopped
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_cleared("async_rst");
        for (int i = 0; i < 4; i++) begin
            ab = 2'(3 - i);
            {a, b} = ab;
            #1;
            chk($sformatf("async_rst_comb_ab%0d", 3 - i), comb_now(), gates_of(ab));
        end
        chk("async_rst_hold_count", edge_count, 0);
        $display("async reset edge_count=%0d seen_mask=%b", edge_count, seen_mask);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            {a, b} = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
